// File: rtl/ibex_instr_realigner_pkg.sv
// Shared types and constants for the instruction realigner and RVC expander.
package ibex_instr_realigner_pkg;

  localparam int unsigned HW_PER_WORD = 2;

  localparam logic [6:0] OPCODE_LOAD   = 7'h03;
  localparam logic [6:0] OPCODE_OP_IMM = 7'h13;
  localparam logic [6:0] OPCODE_STORE  = 7'h23;
  localparam logic [6:0] OPCODE_OP     = 7'h33;
  localparam logic [6:0] OPCODE_LUI    = 7'h37;
  localparam logic [6:0] OPCODE_BRANCH = 7'h63;
  localparam logic [6:0] OPCODE_JALR   = 7'h67;
  localparam logic [6:0] OPCODE_JAL    = 7'h6f;

  typedef struct packed {
    logic [15:0] data;
    logic        err;
  } fetch_hw_t;

  function automatic logic hw_is_compressed(input logic [15:0] hw);
    return hw[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/ibex_rvc_expander.sv
// Pure combinational RV32C to RV32I expansion with illegal-encoding flag.
module ibex_rvc_expander
  import ibex_instr_realigner_pkg::*;
(
  input  logic [15:0] i_instr,
  output logic [31:0] o_instr,
  output logic        o_illegal
);

  logic [15:0] w_i;
  assign w_i = i_instr;

  always_comb begin
    o_instr   = {16'b0, w_i};
    o_illegal = 1'b0;
    case (w_i[1:0])
      2'b00: begin
        case (w_i[15:13])
          3'b000: begin
            o_instr   = {2'b0, w_i[10:7], w_i[12:11], w_i[5], w_i[6], 2'b00, 5'h02,
                         3'b000, 2'b01, w_i[4:2], OPCODE_OP_IMM};
            o_illegal = (w_i[12:5] == 8'h00);
          end
          3'b010: o_instr = {5'b0, w_i[5], w_i[12:10], w_i[6], 2'b00, 2'b01, w_i[9:7],
                             3'b010, 2'b01, w_i[4:2], OPCODE_LOAD};
          3'b110: o_instr = {5'b0, w_i[5], w_i[12], 2'b01, w_i[4:2], 2'b01, w_i[9:7],
                             3'b010, w_i[11:10], w_i[6], 2'b00, OPCODE_STORE};
          default: o_illegal = 1'b1;
        endcase
      end
      2'b01: begin
        case (w_i[15:13])
          3'b000: o_instr = {{6{w_i[12]}}, w_i[12], w_i[6:2], w_i[11:7], 3'b0, w_i[11:7],
                             OPCODE_OP_IMM};
          3'b001, 3'b101: o_instr = {w_i[12], w_i[8], w_i[10:9], w_i[6], w_i[7], w_i[2],
                                     w_i[11], w_i[5:3], {9{w_i[12]}}, 4'b0, ~w_i[15],
                                     OPCODE_JAL};
          3'b010: o_instr = {{6{w_i[12]}}, w_i[12], w_i[6:2], 5'b0, 3'b0, w_i[11:7],
                             OPCODE_OP_IMM};
          3'b011: begin
            if (w_i[11:7] == 5'h02) begin
              o_instr = {{3{w_i[12]}}, w_i[4:3], w_i[5], w_i[2], w_i[6], 4'b0, 5'h02,
                         3'b000, 5'h02, OPCODE_OP_IMM};
            end else begin
              o_instr = {{15{w_i[12]}}, w_i[6:2], w_i[11:7], OPCODE_LUI};
            end
            o_illegal = ({w_i[12], w_i[6:2]} == 6'b0);
          end
          3'b100: begin
            case (w_i[11:10])
              2'b00, 2'b01: begin
                o_instr   = {1'b0, w_i[10], 5'b0, w_i[6:2], 2'b01, w_i[9:7], 3'b101,
                             2'b01, w_i[9:7], OPCODE_OP_IMM};
                o_illegal = w_i[12];
              end
              2'b10: o_instr = {{6{w_i[12]}}, w_i[12], w_i[6:2], 2'b01, w_i[9:7], 3'b111,
                                2'b01, w_i[9:7], OPCODE_OP_IMM};
              default: begin
                case ({w_i[12], w_i[6:5]})
                  3'b000: o_instr = {2'b01, 5'b0, 2'b01, w_i[4:2], 2'b01, w_i[9:7], 3'b000,
                                     2'b01, w_i[9:7], OPCODE_OP};
                  3'b001: o_instr = {7'b0, 2'b01, w_i[4:2], 2'b01, w_i[9:7], 3'b100,
                                     2'b01, w_i[9:7], OPCODE_OP};
                  3'b010: o_instr = {7'b0, 2'b01, w_i[4:2], 2'b01, w_i[9:7], 3'b110,
                                     2'b01, w_i[9:7], OPCODE_OP};
                  3'b011: o_instr = {7'b0, 2'b01, w_i[4:2], 2'b01, w_i[9:7], 3'b111,
                                     2'b01, w_i[9:7], OPCODE_OP};
                  default: o_illegal = 1'b1;
                endcase
              end
            endcase
          end
          default: o_instr = {{4{w_i[12]}}, w_i[6:5], w_i[2], 5'b0, 2'b01, w_i[9:7], 2'b00,
                              w_i[13], w_i[11:10], w_i[4:3], w_i[12], OPCODE_BRANCH};
        endcase
      end
      2'b10: begin
        case (w_i[15:13])
          3'b000: begin
            o_instr   = {7'b0, w_i[6:2], w_i[11:7], 3'b001, w_i[11:7], OPCODE_OP_IMM};
            o_illegal = w_i[12];
          end
          3'b010: begin
            o_instr   = {4'b0, w_i[3:2], w_i[12], w_i[6:4], 2'b00, 5'h02, 3'b010,
                         w_i[11:7], OPCODE_LOAD};
            o_illegal = (w_i[11:7] == 5'b0);
          end
          3'b100: begin
            if (!w_i[12]) begin
              if (w_i[6:2] != 5'b0) begin
                o_instr = {7'b0, w_i[6:2], 5'b0, 3'b0, w_i[11:7], OPCODE_OP};
              end else begin
                o_instr   = {12'b0, w_i[11:7], 3'b0, 5'b0, OPCODE_JALR};
                o_illegal = (w_i[11:7] == 5'b0);
              end
            end else if (w_i[6:2] != 5'b0) begin
              o_instr = {7'b0, w_i[6:2], w_i[11:7], 3'b0, w_i[11:7], OPCODE_OP};
            end else if (w_i[11:7] == 5'b0) begin
              o_instr = 32'h0010_0073;
            end else begin
              o_instr = {12'b0, w_i[11:7], 3'b000, 5'b00001, OPCODE_JALR};
            end
          end
          3'b110: o_instr = {4'b0, w_i[8:7], w_i[12], w_i[6:2], 5'h02, 3'b010, w_i[11:9],
                             2'b00, OPCODE_STORE};
          default: o_illegal = 1'b1;
        endcase
      end
      default: begin
        o_instr   = {16'b0, w_i};
        o_illegal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ibex_instr_realigner.sv
// Halfword FIFO that realigns fetch beats into one expanded instruction per handshake.
// Optional IBEX_REALIGN_BYPASS_EN: present an instruction straight from the beat when empty.
module ibex_instr_realigner
  import ibex_instr_realigner_pkg::*;
#(
  parameter int unsigned FETCH_WORDS = 1,
  parameter int unsigned DEPTH_HW    = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic [31:0]               flush_addr_i,
  input  logic                      fetch_valid_i,
  output logic                      fetch_ready_o,
  input  logic [32*FETCH_WORDS-1:0] fetch_rdata_i,
  input  logic                      fetch_err_i,
  output logic                      instr_valid_o,
  input  logic                      instr_ready_i,
  output logic [31:0]               instr_o,
  output logic [31:0]               instr_raw_o,
  output logic                      instr_is_compressed_o,
  output logic                      instr_illegal_o,
  output logic                      instr_err_o,
  output logic [31:0]               instr_addr_o
);

  localparam int unsigned HW_PER_BEAT = HW_PER_WORD * FETCH_WORDS;
  localparam int unsigned PTR_W       = $clog2(DEPTH_HW);
  localparam int unsigned CNT_W       = $clog2(DEPTH_HW + 1);
  localparam int unsigned SKIP_W      = $clog2(HW_PER_BEAT + 1);

  fetch_hw_t          r_buf [DEPTH_HW];
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [CNT_W-1:0]   r_count;
  logic               r_drop;
  logic [31:0]        r_pc;

  fetch_hw_t          w_beat [HW_PER_BEAT];
  fetch_hw_t          w_h0;
  fetch_hw_t          w_h1;
  logic [CNT_W-1:0]   w_free;
  logic               w_fetch_ready;
  logic               w_push;
  logic               w_byp;
  logic               w_is_comp;
  logic               w_single;
  logic               w_valid;
  logic               w_pop;
  logic [1:0]         w_pop_n;
  logic [SKIP_W-1:0]  w_skip;
  logic [CNT_W-1:0]   w_push_n;
  logic [CNT_W-1:0]   w_pop_buf_n;
  logic [31:0]        w_raw;
  logic [31:0]        w_exp_instr;
  logic               w_exp_illegal;
  logic [31:0]        w_instr;
  logic               w_err;
  logic               w_illegal;
  logic               w_unused_addr0;

  assign w_unused_addr0 = flush_addr_i[0];

  always_comb begin
    for (int k = 0; k < HW_PER_BEAT; k++) begin
      w_beat[k] = '{data: fetch_rdata_i[16*k +: 16], err: fetch_err_i};
    end
  end

  // Acceptance only looks at the registered fill level, never a same-cycle pop.
  assign w_free        = CNT_W'(DEPTH_HW) - r_count;
  assign w_fetch_ready = !flush_i && (w_free >= CNT_W'(HW_PER_BEAT));
  assign w_push        = fetch_valid_i && w_fetch_ready;

`ifdef IBEX_REALIGN_BYPASS_EN
  assign w_byp = (r_count == '0) && !r_drop && w_push;
  assign w_h0  = w_byp ? w_beat[0] : r_buf[r_head];
  assign w_h1  = w_byp ? w_beat[1] : r_buf[PTR_W'(r_head + PTR_W'(1))];
`else
  assign w_byp = 1'b0;
  assign w_h0  = r_buf[r_head];
  assign w_h1  = r_buf[PTR_W'(r_head + PTR_W'(1))];
`endif

  // An errored head halfword goes out on its own so the error is never stuck behind a refill.
  assign w_is_comp = hw_is_compressed(w_h0.data);
  assign w_single  = w_is_comp || w_h0.err;
  assign w_valid   = !flush_i && (w_byp || (w_single ? (r_count >= CNT_W'(1))
                                                     : (r_count >= CNT_W'(2))));
  assign w_pop     = w_valid && instr_ready_i;
  assign w_pop_n   = w_single ? 2'd1 : 2'd2;

  always_comb begin
    w_skip = '0;
    if (r_drop) begin
      w_skip = SKIP_W'(1);
    end else if (w_byp && w_pop) begin
      w_skip = SKIP_W'(w_pop_n);
    end
  end

  assign w_push_n    = w_push ? (CNT_W'(HW_PER_BEAT) - CNT_W'(w_skip)) : '0;
  assign w_pop_buf_n = (w_pop && !w_byp) ? CNT_W'(w_pop_n) : '0;

  ibex_rvc_expander u_expander (
    .i_instr   (w_h0.data),
    .o_instr   (w_exp_instr),
    .o_illegal (w_exp_illegal)
  );

  assign w_raw     = w_single ? {16'b0, w_h0.data} : {w_h1.data, w_h0.data};
  assign w_err     = w_h0.err || (!w_single && w_h1.err);
  assign w_illegal = w_is_comp && !w_h0.err && w_exp_illegal;
  assign w_instr   = (w_is_comp && !w_h0.err) ? w_exp_instr : w_raw;

  assign fetch_ready_o         = w_fetch_ready;
  assign instr_valid_o         = w_valid;
  assign instr_o               = w_valid ? w_instr : '0;
  assign instr_raw_o           = w_valid ? w_raw : '0;
  assign instr_is_compressed_o = w_valid && w_single;
  assign instr_illegal_o       = w_valid && w_illegal;
  assign instr_err_o           = w_valid && w_err;
  assign instr_addr_o          = r_pc;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_drop  <= 1'b0;
      r_pc    <= '0;
    end else if (flush_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_drop  <= flush_addr_i[1];
      r_pc    <= {flush_addr_i[31:1], 1'b0};
    end else begin
      r_head  <= r_head + PTR_W'(w_pop_buf_n);
      r_tail  <= r_tail + PTR_W'(w_push_n);
      r_count <= r_count + w_push_n - w_pop_buf_n;
      if (w_push) begin
        r_drop <= 1'b0;
      end
      if (w_pop) begin
        r_pc <= r_pc + (w_single ? 32'd2 : 32'd4);
      end
    end
  end

  // Skipped halfwords (dropped or bypassed) shift the remainder down onto the tail.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < HW_PER_BEAT; k++) begin
      if (w_push && (SKIP_W'(k) >= w_skip)) begin
        r_buf[PTR_W'(r_tail + PTR_W'(k) - PTR_W'(w_skip))] <= w_beat[k];
      end
    end
  end

endmodule

// File: tb/tb_ibex_instr_realigner.sv
// Directed bench for ibex_instr_realigner with FETCH_WORDS=1, DEPTH_HW=8.
module tb_ibex_instr_realigner;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] flush_addr = '0;
  logic        fvalid = 1'b0;
  logic        fready;
  logic [31:0] frdata = '0;
  logic        ferr = 1'b0;
  logic        ivalid;
  logic        iready = 1'b0;
  logic [31:0] instr;
  logic [31:0] raw;
  logic        is_comp;
  logic        illegal;
  logic        ierr;
  logic [31:0] iaddr;

  int n_cmp  = 0;
  int n_fail = 0;

  ibex_instr_realigner #(.FETCH_WORDS(1), .DEPTH_HW(8)) dut (
    .clk_i                 (clk),
    .rst_i                 (rst),
    .flush_i               (flush),
    .flush_addr_i          (flush_addr),
    .fetch_valid_i         (fvalid),
    .fetch_ready_o         (fready),
    .fetch_rdata_i         (frdata),
    .fetch_err_i           (ferr),
    .instr_valid_o         (ivalid),
    .instr_ready_i         (iready),
    .instr_o               (instr),
    .instr_raw_o           (raw),
    .instr_is_compressed_o (is_comp),
    .instr_illegal_o       (illegal),
    .instr_err_o           (ierr),
    .instr_addr_o          (iaddr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; fvalid = 1'b0; iready = 1'b0; ferr = 1'b0; frdata = '0;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic push(input logic [31:0] d, input logic e);
    fvalid = 1'b1; frdata = d; ferr = e;
    step();
    fvalid = 1'b0; ferr = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    logic [103:0] got;
    do_reset();
    got = {ivalid, iaddr, instr, raw, is_comp, illegal, ierr, fready};
    n_cmp++;
    if (got !== {1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      $display("FAIL reset_state got %h exp %h", got,
               {1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1});
      n_fail++;
    end
  endtask

  task automatic test_aligned();
    logic [65:0] got;
    do_reset();
    fvalid = 1'b1; frdata = 32'h0001_0001;
    #1;
    n_cmp++;
    if (ivalid !== 1'b0) begin
      $display("FAIL aligned_no_comb_path got %b exp 0", ivalid); n_fail++;
    end
    step();
    frdata = 32'h0000_0513;
    #1;
    got = {ivalid, iaddr, instr, is_comp};
    n_cmp++;
    if (got !== {1'b1, 32'h0, 32'h13, 1'b1}) begin
      $display("FAIL aligned_first got %h exp %h", got, {1'b1, 32'h0, 32'h13, 1'b1}); n_fail++;
    end
    step();
    fvalid = 1'b0; iready = 1'b1;
    step();
    got = {ivalid, iaddr, instr, is_comp};
    n_cmp++;
    if (got !== {1'b1, 32'h2, 32'h13, 1'b1}) begin
      $display("FAIL aligned_second got %h exp %h", got, {1'b1, 32'h2, 32'h13, 1'b1}); n_fail++;
    end
    step();
    got = {ivalid, iaddr, instr, is_comp};
    n_cmp++;
    if (got !== {1'b1, 32'h4, 32'h513, 1'b0} || raw !== 32'h513) begin
      $display("FAIL aligned_addi got %h raw %h exp %h raw 00000513", got, raw,
               {1'b1, 32'h4, 32'h513, 1'b0});
      n_fail++;
    end
    step();
    n_cmp++;
    if ({ivalid, iaddr} !== {1'b0, 32'h8}) begin
      $display("FAIL aligned_drain got %h exp %h", {ivalid, iaddr}, {1'b0, 32'h8}); n_fail++;
    end
  endtask

  task automatic test_straddle();
    logic [65:0] got;
    do_reset();
    push(32'h0513_0001, 1'b0);
    got = {ivalid, iaddr, instr, is_comp};
    n_cmp++;
    if (got !== {1'b1, 32'h0, 32'h13, 1'b1}) begin
      $display("FAIL straddle_cnop got %h exp %h", got, {1'b1, 32'h0, 32'h13, 1'b1}); n_fail++;
    end
    iready = 1'b1;
    step();
    n_cmp++;
    if ({ivalid, iaddr} !== {1'b0, 32'h2}) begin
      $display("FAIL straddle_wait got %h exp %h", {ivalid, iaddr}, {1'b0, 32'h2}); n_fail++;
    end
    push(32'h0001_0000, 1'b0);
    got = {ivalid, iaddr, instr, is_comp};
    n_cmp++;
    if (got !== {1'b1, 32'h2, 32'h513, 1'b0}) begin
      $display("FAIL straddle_addi got %h exp %h", got, {1'b1, 32'h2, 32'h513, 1'b0}); n_fail++;
    end
    step();
    got = {ivalid, iaddr, instr, is_comp};
    n_cmp++;
    if (got !== {1'b1, 32'h6, 32'h13, 1'b1}) begin
      $display("FAIL straddle_tail got %h exp %h", got, {1'b1, 32'h6, 32'h13, 1'b1}); n_fail++;
    end
    step();
    iready = 1'b0;
  endtask

  task automatic test_flush();
    logic [65:0] got;
    do_reset();
    push(32'h0001_0001, 1'b0);
    flush = 1'b1; flush_addr = 32'h0000_0103;
    fvalid = 1'b1; frdata = 32'h1234_5678; iready = 1'b1;
    #1;
    n_cmp++;
    if ({ivalid, fready} !== 2'b00) begin
      $display("FAIL flush_forces_low got %b exp 00", {ivalid, fready}); n_fail++;
    end
    step();
    flush = 1'b0; fvalid = 1'b0; iready = 1'b0;
    #1;
    n_cmp++;
    if ({ivalid, iaddr, fready} !== {1'b0, 32'h102, 1'b1}) begin
      $display("FAIL flush_no_handshake got %h exp %h", {ivalid, iaddr, fready},
               {1'b0, 32'h102, 1'b1});
      n_fail++;
    end
    push(32'h4501_FFFF, 1'b0);
    got = {ivalid, iaddr, instr, is_comp};
    n_cmp++;
    if (got !== {1'b1, 32'h102, 32'h513, 1'b1} || raw !== 32'h4501 || illegal !== 1'b0) begin
      $display("FAIL flush_cli got %h raw %h ill %b exp %h raw 00004501 ill 0", got, raw,
               illegal, {1'b1, 32'h102, 32'h513, 1'b1});
      n_fail++;
    end
    iready = 1'b1;
    step();
    iready = 1'b0;
    n_cmp++;
    if ({ivalid, iaddr} !== {1'b0, 32'h104}) begin
      $display("FAIL flush_after got %h exp %h", {ivalid, iaddr}, {1'b0, 32'h104}); n_fail++;
    end
  endtask

  task automatic test_backpressure();
    logic [65:0] got;
    do_reset();
    fvalid = 1'b1; frdata = 32'h0001_0001;
    for (int i = 1; i <= 5; i++) begin
      step();
      got = {ivalid, iaddr, instr, fready};
      n_cmp++;
      if (got !== {1'b1, 32'h0, 32'h13, (i < 4)}) begin
        $display("FAIL backpressure_fill%0d got %h exp %h", i, got,
                 {1'b1, 32'h0, 32'h13, (i < 4)});
        n_fail++;
      end
    end
    fvalid = 1'b0; iready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      got = {ivalid, iaddr, instr, fready};
      n_cmp++;
      if (got !== {(i < 8), 32'(2 * i), ((i < 8) ? 32'h13 : 32'h0), (i >= 2)}) begin
        $display("FAIL backpressure_pop%0d got %h exp %h", i, got,
                 {(i < 8), 32'(2 * i), ((i < 8) ? 32'h13 : 32'h0), (i >= 2)});
        n_fail++;
      end
    end
    iready = 1'b0;
  endtask

  task automatic test_error();
    logic [67:0] got;
    do_reset();
    push(32'h0003_0001, 1'b0);
    push(32'h0000_0000, 1'b1);
    iready = 1'b1;
    step();
    got = {ivalid, iaddr, instr, is_comp, illegal, ierr};
    n_cmp++;
    if (got !== {1'b1, 32'h2, 32'h3, 1'b0, 1'b0, 1'b1}) begin
      $display("FAIL error_upper got %h exp %h", got, {1'b1, 32'h2, 32'h3, 1'b0, 1'b0, 1'b1});
      n_fail++;
    end
    step();
    got = {ivalid, iaddr, raw, is_comp, illegal, ierr};
    n_cmp++;
    if (got !== {1'b1, 32'h6, 32'h0, 1'b1, 1'b0, 1'b1}) begin
      $display("FAIL error_head got %h exp %h", got, {1'b1, 32'h6, 32'h0, 1'b1, 1'b0, 1'b1});
      n_fail++;
    end
    step();
    iready = 1'b0;
    n_cmp++;
    if ({ivalid, iaddr} !== {1'b0, 32'h8}) begin
      $display("FAIL error_drain got %h exp %h", {ivalid, iaddr}, {1'b0, 32'h8}); n_fail++;
    end
  endtask

  task automatic test_back_to_back();
    logic [64:0] got;
    do_reset();
    fvalid = 1'b1; frdata = 32'h4501_0001; iready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      got = {ivalid, iaddr, instr};
      n_cmp++;
      if (got !== {1'b1, 32'(2 * i), ((i % 2) == 1) ? 32'h513 : 32'h13}) begin
        $display("FAIL back_to_back%0d got %h exp %h", i, got,
                 {1'b1, 32'(2 * i), ((i % 2) == 1) ? 32'h513 : 32'h13});
        n_fail++;
      end
    end
    fvalid = 1'b0; iready = 1'b0;
  endtask

  task automatic test_reset_midop();
    do_reset();
    push(32'h0001_0001, 1'b0);
    push(32'h0001_0001, 1'b0);
    push(32'h0001_0001, 1'b0);
    n_cmp++;
    if ({ivalid, fready} !== 2'b11) begin
      $display("FAIL midop_before got %b exp 11", {ivalid, fready}); n_fail++;
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({ivalid, iaddr, fready} !== {1'b0, 32'h0, 1'b1}) begin
      $display("FAIL midop_async got %h exp %h", {ivalid, iaddr, fready}, {1'b0, 32'h0, 1'b1});
      n_fail++;
    end
    step();
    rst = 1'b0;
    step();
    n_cmp++;
    if ({ivalid, iaddr, fready} !== {1'b0, 32'h0, 1'b1}) begin
      $display("FAIL midop_after got %h exp %h", {ivalid, iaddr, fready}, {1'b0, 32'h0, 1'b1});
      n_fail++;
    end
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_straddle();
    test_flush();
    test_backpressure();
    test_error();
    test_back_to_back();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
